// File: rtl/noc_pkg.sv
// Shared NoC router types: flit layout, port encoding and XY routing helper.
// Flit type lives in the top two bits; head flits carry dest X/Y in the low bits.
package noc_pkg;

   localparam int FLIT_W  = 32;
   localparam int COORD_W = 4;
   localparam int PORT_N  = 5;
   localparam int PORT_W  = $clog2(PORT_N);

   typedef enum logic [1:0] {
      BODY     = 2'b00,
      HEAD     = 2'b01,
      TAIL     = 2'b10,
      HEADTAIL = 2'b11
   } flit_type_e;

   typedef enum logic [PORT_W-1:0] {
      LOCAL = 3'd0,
      EAST  = 3'd1,
      WEST  = 3'd2,
      NORTH = 3'd3,
      SOUTH = 3'd4
   } port_e;

   typedef enum logic {
      ST_IDLE,
      ST_ACTIVE
   } in_state_e;

   typedef struct packed {
      flit_type_e                      ftype;
      logic [FLIT_W-2-2*COORD_W-1:0]   payload;
      logic [COORD_W-1:0]              dst_x;
      logic [COORD_W-1:0]              dst_y;
   } hdr_t;

   // Bit 0 of the type marks a packet start, bit 1 a packet end.
   function automatic logic is_head(input flit_type_e t);
      return t[0];
   endfunction

   function automatic logic is_tail(input flit_type_e t);
      return t[1];
   endfunction

   function automatic port_e route_xy(
      input logic [COORD_W-1:0] dx,
      input logic [COORD_W-1:0] dy,
      input logic [COORD_W-1:0] my_x,
      input logic [COORD_W-1:0] my_y
   );
      if (dx > my_x)
         return EAST;
      else if (dx < my_x)
         return WEST;
      else if (dy > my_y)
         return NORTH;
      else if (dy < my_y)
         return SOUTH;
      return LOCAL;
   endfunction

endpackage

// File: rtl/flit_fifo.sv
// Registered-output flit FIFO; data visible the cycle after push, no fall-through.
// full/empty from (AW+1)-bit wrapping pointers; caller must not push when full.
module flit_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int            AW      = $clog2(DEPTH);
   localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [W-1:0] mem_q [DEPTH];
   logic         do_push;
   logic         do_pop;

   always_comb begin
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      empty    = (wr_ptr_q == rd_ptr_q);
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push)
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      dout = mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: pointers alone define what is valid.
   always_ff @(posedge clk_i) begin
      if (do_push)
         mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

   assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));
   assert property (@(posedge clk_i) disable iff (rst_i) !(pop && empty));

endmodule

// File: rtl/inport_unit.sv
// Router input port: FIFO + XY route + wormhole request; head 2 cycles in-to-out, body 1.
// ready_o = FIFO not full; request held across grant/ready stalls until the tail fires.
module inport_unit
   import noc_pkg::*;
#(
   parameter int                 DEPTH = 4,
   parameter logic [COORD_W-1:0] MY_X  = '0,
   parameter logic [COORD_W-1:0] MY_Y  = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [FLIT_W-1:0] flit_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic [PORT_W-1:0] port_o,
   output logic              req_o,
   input  logic              grt_i,
   input  logic              ready_i,
   output logic [FLIT_W-1:0] flit_o,
   output logic              valid_o,
   output logic              err_o
);

   in_state_e          state_q, state_d;
   port_e              port_q, port_d;
   logic               err_q, err_d;

   logic [FLIT_W-1:0]  fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_push;
   logic               fifo_pop;
   hdr_t               head;
   logic               fire;
   logic               stray;

   assign fifo_push = valid_i && ready_o;

   flit_fifo #(
      .DEPTH (DEPTH),
      .W     (FLIT_W)
   ) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (flit_i),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      head     = fifo_dout;
      fire     = (state_q == ST_ACTIVE) && grt_i && ready_i && !fifo_empty;
      // A non-head flit reaching the front while idle has no packet to join.
      stray    = (state_q == ST_IDLE) && !fifo_empty && !is_head(head.ftype);
      fifo_pop = fire || stray;
      state_d  = state_q;
      port_d   = port_q;
      err_d    = stray;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty && is_head(head.ftype)) begin
               port_d  = route_xy(head.dst_x, head.dst_y, MY_X, MY_Y);
               state_d = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (fire && is_tail(head.ftype))
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         port_q  <= LOCAL;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         err_q   <= err_d;
      end
   end

   assign ready_o = !fifo_full;
   assign req_o   = (state_q == ST_ACTIVE);
   assign port_o  = port_q;
   assign flit_o  = head;
   assign valid_o = fire;
   assign err_o   = err_q;

   assert property (@(posedge clk_i) disable iff (rst_i) valid_o |-> req_o);
   assert property (@(posedge clk_i) disable iff (rst_i) !(valid_o && err_o));

endmodule

// File: tb/tb_inport_unit.sv
// Scoreboard bench for inport_unit: directed timing checks plus random packet traffic.
module tb_inport_unit;

   localparam int DEPTH = 4;
   localparam int MY_X  = 1;
   localparam int MY_Y  = 1;

   localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;
   localparam logic [2:0] P_LOCAL = 3'd0, P_EAST = 3'd1, P_WEST = 3'd2,
                          P_NORTH = 3'd3, P_SOUTH = 3'd4;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [31:0] flit_i;
   logic        valid_i;
   logic        ready_o;
   logic [2:0]  port_o;
   logic        req_o;
   logic        grt_i;
   logic        ready_i;
   logic [31:0] flit_o;
   logic        valid_o;
   logic        err_o;

   always #5 clk = ~clk;

   inport_unit #(
      .DEPTH (DEPTH),
      .MY_X  (4'(MY_X)),
      .MY_Y  (4'(MY_Y))
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .flit_i  (flit_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .port_o  (port_o),
      .req_o   (req_o),
      .grt_i   (grt_i),
      .ready_i (ready_i),
      .flit_o  (flit_o),
      .valid_o (valid_o),
      .err_o   (err_o)
   );

   typedef struct {
      bit          is_err;
      logic [31:0] flit;
      logic [2:0]  port;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   bit         in_pkt = 0;
   logic [2:0] cur_port = P_LOCAL;
   int         vectors = 0;
   int         miscompares = 0;
   bit         rand_bp = 0;
   int         errs_seen;
   int         vld_seen;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, need 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [2:0] ref_route(input int dx, input int dy);
      int ex, ey;
      ex = dx - MY_X;
      ey = dy - MY_Y;
      if (ex != 0) return (ex > 0) ? P_EAST : P_WEST;
      if (ey != 0) return (ey > 0) ? P_NORTH : P_SOUTH;
      return P_LOCAL;
   endfunction

   function automatic logic [31:0] mk(input logic [1:0] t, input int x, input int y);
      logic [21:0] pl;
      pl = 22'($urandom);
      return {t, pl, 4'(x), 4'(y)};
   endfunction

   // Stream-level model: packets pass through in order, stray non-heads become error events.
   function automatic void model_push(input logic [31:0] f);
      exp_t e;
      logic [1:0] t;
      t = f[31:30];
      e.flit = f;
      e.is_err = 0;
      if (!in_pkt) begin
         if (t == T_HEAD || t == T_HT) begin
            cur_port = ref_route(int'(f[7:4]), int'(f[3:0]));
            in_pkt = (t == T_HEAD);
         end else begin
            e.is_err = 1;
         end
      end else if (t == T_TAIL || t == T_HT) begin
         in_pkt = 0;
      end
      e.port = cur_port;
      exp_q.push_back(e);
   endfunction

   task automatic send(input logic [31:0] f);
      int guard;
      guard = 0;
      flit_i = f;
      valid_i = 1'b1;
      forever begin
         @(negedge clk);
         if (ready_o) break;
         @(posedge clk);
         #1;
         guard++;
         if (guard > 500) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: ready_o stuck at %0b, need 1", ready_o);
            valid_i = 1'b0;
            return;
         end
      end
      model_push(f);
      @(posedge clk);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic t2_check();
      int n;
      n = 0;
      @(negedge clk);
      while (!req_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t2_req_rise", req_o, 1);
      chk("t2_port", port_o, P_SOUTH);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         chk($sformatf("t2_fire%0d", i), valid_o, 1);
         chk($sformatf("t2_req_held%0d", i), req_o, 1);
      end
      @(negedge clk);
      chk("t2_req_low_after_tail", req_o, 0);
   endtask

   // Monitor: every output event is matched against the head of the expected stream.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_i === 1'b0 && (valid_o || err_o)) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL mon_unexpected: valid_o=%0b err_o=%0b flit=0x%0h, need no event",
                        valid_o, err_o, flit_o);
            end else begin
               mon_e = exp_q.pop_front();
               chk("mon_event_kind", {valid_o, err_o}, mon_e.is_err ? 2'b01 : 2'b10);
               if (!mon_e.is_err) begin
                  chk("mon_flit", flit_o, mon_e.flit);
                  chk("mon_port", port_o, mon_e.port);
                  chk("mon_req", req_o, 1);
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_bp) begin
            grt_i   = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 4) != 0);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1; valid_i = 1'b0; flit_i = '0; grt_i = 1'b0; ready_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", ready_o, 1);
      chk("rst_req", req_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_port", port_o, P_LOCAL);
      @(posedge clk); #1;
      rst_i = 1'b0; grt_i = 1'b1; ready_i = 1'b1;

      // Single HEADTAIL, 2-cycle latency.
      send(mk(T_HT, 2, 1));
      @(negedge clk);
      chk("t1_req_while_routing", req_o, 0);
      @(negedge clk);
      chk("t1_req", req_o, 1);
      chk("t1_port", port_o, P_EAST);
      chk("t1_fire", valid_o, 1);
      @(negedge clk);
      chk("t1_req_low", req_o, 0);
      chk("t1_valid_low", valid_o, 0);
      repeat (2) @(posedge clk); #1;

      // 4-flit packet, consecutive fires.
      fork
         begin
            send(mk(T_HEAD, 1, 0));
            send(mk(T_BODY, 7, 7));
            send(mk(T_BODY, 5, 9));
            send(mk(T_TAIL, 3, 2));
         end
         t2_check();
      join
      @(posedge clk); #1;

      // Back-pressure: fill then drain.
      grt_i = 1'b0;
      send(mk(T_HEAD, 1, 2));
      send(mk(T_BODY, 0, 0));
      send(mk(T_BODY, 1, 1));
      send(mk(T_TAIL, 2, 2));
      @(negedge clk);
      chk("t3_full", ready_o, 0);
      chk("t3_req", req_o, 1);
      chk("t3_port", port_o, P_NORTH);
      @(posedge clk); #1;
      grt_i = 1'b1;
      @(negedge clk);
      chk("t3_first_pop", valid_o, 1);
      chk("t3_still_full", ready_o, 0);
      @(negedge clk);
      chk("t3_ready_back", ready_o, 1);
      chk("t3_pop1", valid_o, 1);
      @(negedge clk);
      chk("t3_pop2", valid_o, 1);
      @(negedge clk);
      chk("t3_pop3", valid_o, 1);
      @(negedge clk);
      chk("t3_req_low", req_o, 0);
      @(posedge clk); #1;

      // Grant toggling while the FIFO is empty mid-packet.
      send(mk(T_HEAD, 0, 1));
      @(negedge clk);
      @(negedge clk);
      chk("t4_head_fire", valid_o, 1);
      chk("t4_port", port_o, P_WEST);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         grt_i = ~grt_i;
         @(negedge clk);
         chk($sformatf("t4_req_held%0d", i), req_o, 1);
      end
      @(posedge clk); #1;
      grt_i = 1'b0;
      send(mk(T_BODY, 4, 4));
      @(negedge clk);
      chk("t4_req_no_grant", req_o, 1);
      chk("t4_no_fire", valid_o, 0);
      @(posedge clk); #1;
      grt_i = 1'b1;
      send(mk(T_TAIL, 6, 6));
      repeat (4) @(negedge clk);
      chk("t4_all_delivered", exp_q.size(), 0);
      chk("t4_req_low", req_o, 0);
      @(posedge clk); #1;

      // Stray BODY in IDLE.
      send(mk(T_BODY, 2, 2));
      errs_seen = 0;
      vld_seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (err_o) errs_seen++;
         if (valid_o) vld_seen++;
      end
      chk("t5_err_pulses", errs_seen, 1);
      chk("t5_no_output", vld_seen, 0);
      chk("t5_req_idle", req_o, 0);
      @(posedge clk); #1;
      send(mk(T_HT, 1, 1));
      repeat (4) @(negedge clk);
      chk("t5_after_stray", exp_q.size(), 0);
      @(posedge clk); #1;

      // Reset mid-packet.
      grt_i = 1'b0;
      send(mk(T_HEAD, 3, 1));
      send(mk(T_BODY, 8, 8));
      @(negedge clk);
      chk("t6_req_before_rst", req_o, 1);
      @(posedge clk); #2;
      rst_i = 1'b1;
      exp_q.delete();
      in_pkt = 0;
      #1;
      chk("t6_req_async", req_o, 0);
      chk("t6_ready_async", ready_o, 1);
      @(posedge clk); #1;
      rst_i = 1'b0;
      grt_i = 1'b1;
      send(mk(T_HT, 1, 3));
      repeat (4) @(negedge clk);
      chk("t6_after_reset", exp_q.size(), 0);
      chk("t6_req_low", req_o, 0);
      @(posedge clk); #1;

      // Random traffic with random grant/ready stalls.
      rand_bp = 1;
      for (int p = 0; p < 80; p++) begin
         int len;
         if ($urandom_range(0, 6) == 0)
            send(mk($urandom_range(0, 1) ? T_BODY : T_TAIL, $urandom_range(0, 2), $urandom_range(0, 2)));
         len = $urandom_range(1, 5);
         if (len == 1) begin
            send(mk(T_HT, $urandom_range(0, 2), $urandom_range(0, 2)));
         end else begin
            send(mk(T_HEAD, $urandom_range(0, 2), $urandom_range(0, 2)));
            for (int b = 0; b < len - 2; b++)
               send(mk(T_BODY, $urandom_range(0, 15), $urandom_range(0, 15)));
            send(mk(T_TAIL, $urandom_range(0, 15), $urandom_range(0, 15)));
         end
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
      rand_bp = 0;
      @(posedge clk); #1;
      grt_i = 1'b1;
      ready_i = 1'b1;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++)
         @(negedge clk);
      repeat (2) @(negedge clk);
      chk("rand_drained", exp_q.size(), 0);
      chk("rand_req_low", req_o, 0);
      chk("rand_ready", ready_o, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
